// File: rtl/pu_pkg.sv
// ---------------------------------------------------------------------------
// pu_pkg
// Shared definitions for the processing-unit blocks.
//   node_id_t       : node identifier type used on the frontier datapath
//   ptr_width()     : pointer/count width for a given queue depth
//                     (clog2(depth) address bits plus one wrap bit)
//   LEGAL_LANE_MASK : bit n set when n push lanes is a supported lane count
//   lanes_legal()   : lane-count check built on LEGAL_LANE_MASK
// ---------------------------------------------------------------------------
package pu_pkg;

    localparam int NODE_ID_BITS = 32;
    typedef logic [NODE_ID_BITS-1:0] node_id_t;

    // Supported lane counts are 1, 2, 4 and 8.
    localparam logic [8:0] LEGAL_LANE_MASK = 9'b1_0001_0110;

    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic bit lanes_legal(input int lanes);
        if (lanes < 1 || lanes > 8) begin
            return 1'b0;
        end
        return LEGAL_LANE_MASK[lanes];
    endfunction

endpackage

// File: rtl/pu_frontier_queue_if.sv
// ---------------------------------------------------------------------------
// pu_frontier_queue_if
// Push/pop bundle of the frontier queue.
//   push_valid  : per-lane valid mask from the expansion stage
//   push_data   : lane i at bits [i*NODE_BITS +: NODE_BITS]
//   push_ready  : queue can take a full lane group this cycle
//   pop_valid   : head entry present on pop_data
//   pop_data    : head entry (registered)
//   pop_ready   : dispatcher takes the head
//   count       : entries accepted and not yet popped
//   almost_full : count at or above the throttle level
// Modports: master = producer/consumer side, slave = queue side.
// ---------------------------------------------------------------------------
interface pu_frontier_queue_if
    import pu_pkg::*;
#(
    parameter int NODE_BITS   = 32,
    parameter int QUEUE_DEPTH = 1024,
    parameter int PUSH_LANES  = 4
);

    localparam int CNT_W = ptr_width(QUEUE_DEPTH);

    logic [PUSH_LANES-1:0]           push_valid;
    logic [PUSH_LANES*NODE_BITS-1:0] push_data;
    logic                            push_ready;
    logic                            pop_valid;
    logic [NODE_BITS-1:0]            pop_data;
    logic                            pop_ready;
    logic [CNT_W-1:0]                count;
    logic                            almost_full;

    modport master (
        output push_valid, push_data, pop_ready,
        input  push_ready, pop_valid, pop_data, count, almost_full
    );

    modport slave (
        input  push_valid, push_data, pop_ready,
        output push_ready, pop_valid, pop_data, count, almost_full
    );

endinterface

// File: rtl/pu_fq_lane_compactor.sv
// ---------------------------------------------------------------------------
// pu_fq_lane_compactor
// Combinational lane compaction for the banked frontier queue. Valid lanes
// are packed in lane order onto consecutive slots starting at wr_addr; slot
// k lives in bank k mod PUSH_LANES, so each bank sees at most one write.
//   push_valid : per-lane valid mask
//   push_data  : packed lane data
//   wr_addr    : write pointer without its wrap bit
//   bank_we    : per-bank write enable (before the accept qualifier)
//   bank_idx   : per-bank row index
//   bank_wdata : per-bank write data
//   num_valid  : popcount of push_valid
// ---------------------------------------------------------------------------
module pu_fq_lane_compactor
    import pu_pkg::*;
#(
    parameter int NODE_BITS   = 32,
    parameter int QUEUE_DEPTH = 1024,
    parameter int PUSH_LANES  = 4,
    localparam int ADDR_W     = $clog2(QUEUE_DEPTH),
    localparam int LANE_SHIFT = $clog2(PUSH_LANES),
    localparam int IDX_W      = ADDR_W - LANE_SHIFT,
    localparam int NUM_W      = $clog2(PUSH_LANES + 1)
) (
    input  logic [PUSH_LANES-1:0]                push_valid,
    input  logic [PUSH_LANES*NODE_BITS-1:0]      push_data,
    input  logic [ADDR_W-1:0]                    wr_addr,
    output logic [PUSH_LANES-1:0]                bank_we,
    output logic [PUSH_LANES-1:0][IDX_W-1:0]     bank_idx,
    output logic [PUSH_LANES-1:0][NODE_BITS-1:0] bank_wdata,
    output logic [NUM_W-1:0]                     num_valid
);

    logic [PUSH_LANES-1:0][NUM_W-1:0] lane_rank;
    logic [PUSH_LANES-1:0][NUM_W-1:0] bank_pos;

    // Exclusive prefix popcount: a lane's rank is the number of valid lanes
    // below it, i.e. its offset from wr_addr once gaps are squeezed out.
    always_comb begin
        logic [NUM_W-1:0] running;
        running   = '0;
        lane_rank = '0;
        for (int i = 0; i < PUSH_LANES; i++) begin
            lane_rank[i] = running;
            running      = running + NUM_W'(push_valid[i]);
        end
        num_valid = running;
    end

    // Bank b receives the slot at offset (b - wr_addr) mod PUSH_LANES from
    // wr_addr, written only if that many lanes are valid. The row index is
    // the slot address with the bank bits dropped; truncation gives the
    // natural wrap across the last slot.
    always_comb begin
        bank_pos   = '0;
        bank_we    = '0;
        bank_idx   = '0;
        bank_wdata = '0;
        for (int b = 0; b < PUSH_LANES; b++) begin
            bank_pos[b] = NUM_W'((b - int'(wr_addr)) & (PUSH_LANES - 1));
            bank_we[b]  = bank_pos[b] < num_valid;
            bank_idx[b] = IDX_W'((int'(wr_addr) + int'(bank_pos[b])) >> LANE_SHIFT);
            for (int i = 0; i < PUSH_LANES; i++) begin
                if (push_valid[i] && (lane_rank[i] == bank_pos[b])) begin
                    bank_wdata[b] = push_data[i*NODE_BITS +: NODE_BITS];
                end
            end
        end
    end

endmodule

// File: rtl/pu_frontier_queue.sv
// ---------------------------------------------------------------------------
// pu_frontier_queue
// Multi-lane BFS frontier queue. Up to PUSH_LANES node IDs per cycle are
// compacted in lane order into a banked circular buffer; the head is
// presented on a registered first-word-fall-through pop port.
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   clear      : synchronous flush (pointers, count, pop_valid)
//   bus        : pu_frontier_queue_if slave (push, pop, count, almost_full)
// Optional feature macro PU_FQ_STATS_EN adds:
//   stat_pushed : saturating total of accepted nodes
//   stat_peak   : highest count reached
// ---------------------------------------------------------------------------
module pu_frontier_queue
    import pu_pkg::*;
#(
    parameter int NODE_BITS    = 32,
    parameter int QUEUE_DEPTH  = 1024,
    parameter int PUSH_LANES   = 4,
    parameter int AFULL_THRESH = QUEUE_DEPTH - 2 * PUSH_LANES,
    localparam int CNT_W       = ptr_width(QUEUE_DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    pu_frontier_queue_if.slave       bus
`ifdef PU_FQ_STATS_EN
    ,
    output logic [31:0]              stat_pushed,
    output logic [CNT_W-1:0]         stat_peak
`endif
);

    localparam int ADDR_W     = $clog2(QUEUE_DEPTH);
    localparam int LANE_SHIFT = $clog2(PUSH_LANES);
    localparam int LANE_SEL_W = (LANE_SHIFT > 0) ? LANE_SHIFT : 1;
    localparam int IDX_W      = ADDR_W - LANE_SHIFT;
    localparam int BANK_DEPTH = QUEUE_DEPTH / PUSH_LANES;
    localparam int NUM_W      = $clog2(PUSH_LANES + 1);

    localparam logic [CNT_W-1:0] READY_LIMIT = CNT_W'(QUEUE_DEPTH - PUSH_LANES);
    localparam logic [CNT_W-1:0] AFULL_LEVEL = CNT_W'(AFULL_THRESH);

    if (!lanes_legal(PUSH_LANES)) begin : g_lane_check
        $error("pu_frontier_queue: PUSH_LANES must be 1, 2, 4 or 8");
    end

    logic [CNT_W-1:0]                wr_ptr;
    logic [CNT_W-1:0]                rd_ptr;
    logic [CNT_W-1:0]                count_q;
    logic [CNT_W-1:0]                stored;
    logic [CNT_W-1:0]                pushed_n;
    logic [CNT_W-1:0]                count_next;
    logic                            push_ready_c;
    logic                            push_fire;
    logic                            pop_fire;
    logic                            load_head;
    logic                            pop_valid_q;
    logic [NODE_BITS-1:0]            pop_data_q;
    logic [NODE_BITS-1:0]            head_data;
    logic [IDX_W-1:0]                rd_idx;
    logic [LANE_SEL_W-1:0]           rd_bank;
    logic [NUM_W-1:0]                num_valid;
    logic [PUSH_LANES-1:0]           bank_we;
    logic [PUSH_LANES-1:0][IDX_W-1:0]     bank_idx;
    logic [PUSH_LANES-1:0][NODE_BITS-1:0] bank_wdata;
    logic [PUSH_LANES-1:0][NODE_BITS-1:0] bank_rdata;

    pu_fq_lane_compactor #(
        .NODE_BITS   (NODE_BITS),
        .QUEUE_DEPTH (QUEUE_DEPTH),
        .PUSH_LANES  (PUSH_LANES)
    ) u_compactor (
        .push_valid (bus.push_valid),
        .push_data  (bus.push_data),
        .wr_addr    (wr_ptr[ADDR_W-1:0]),
        .bank_we    (bank_we),
        .bank_idx   (bank_idx),
        .bank_wdata (bank_wdata),
        .num_valid  (num_valid)
    );

    // Ready depends only on count, so the producer never sees a
    // combinational path from its own valid back to ready.
    assign push_ready_c = (count_q <= READY_LIMIT);
    assign push_fire    = push_ready_c && (|bus.push_valid) && !clear;
    assign pop_fire     = pop_valid_q && bus.pop_ready;

    // stored counts entries in the banks that have not yet moved into the
    // output register. The head reloads whenever the register is empty or
    // being consumed, which keeps back-to-back pops bubble-free.
    assign stored     = wr_ptr - rd_ptr;
    assign load_head  = (!pop_valid_q || pop_fire) && (stored != '0);
    assign pushed_n   = push_fire ? CNT_W'(num_valid) : '0;
    assign count_next = count_q + pushed_n - CNT_W'(pop_fire);

    assign rd_idx    = rd_ptr[ADDR_W-1:LANE_SHIFT];
    assign rd_bank   = LANE_SEL_W'(rd_ptr[ADDR_W-1:0] & ADDR_W'(PUSH_LANES - 1));
    assign head_data = bank_rdata[rd_bank];

    // One 1W1R bank per lane; contents are deliberately not reset or cleared.
    for (genvar b = 0; b < PUSH_LANES; b++) begin : g_bank
        logic [NODE_BITS-1:0] bank_mem [BANK_DEPTH];

        always_ff @(posedge clk) begin
            if (push_fire && bank_we[b]) begin
                bank_mem[bank_idx[b]] <= bank_wdata[b];
            end
        end

        assign bank_rdata[b] = bank_mem[rd_idx];
    end

    // Pointer, count and output-register state. clear wins over any push or
    // pop in the same cycle; pop_data keeps its stale value on clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_q     <= '0;
            pop_valid_q <= 1'b0;
            pop_data_q  <= '0;
        end else if (clear) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_q     <= '0;
            pop_valid_q <= 1'b0;
        end else begin
            if (push_fire) begin
                wr_ptr <= wr_ptr + CNT_W'(num_valid);
            end
            if (load_head) begin
                pop_data_q  <= head_data;
                pop_valid_q <= 1'b1;
                rd_ptr      <= rd_ptr + CNT_W'(1);
            end else if (pop_fire) begin
                pop_valid_q <= 1'b0;
            end
            count_q <= count_next;
        end
    end

    assign bus.push_ready  = push_ready_c;
    assign bus.pop_valid   = pop_valid_q;
    assign bus.pop_data    = pop_data_q;
    assign bus.count       = count_q;
    assign bus.almost_full = (count_q >= AFULL_LEVEL);

`ifdef PU_FQ_STATS_EN
    logic [32:0] pushed_sum;

    assign pushed_sum = {1'b0, stat_pushed} + 33'(pushed_n);

    // Peak tracks the post-update count so it is current the cycle after
    // the push that set it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_pushed <= '0;
            stat_peak   <= '0;
        end else if (clear) begin
            stat_pushed <= '0;
            stat_peak   <= '0;
        end else begin
            stat_pushed <= pushed_sum[32] ? '1 : pushed_sum[31:0];
            if (count_next > stat_peak) begin
                stat_peak <= count_next;
            end
        end
    end
`endif

endmodule

// File: doc/pu_frontier_queue.md
# pu_frontier_queue

Multi-lane BFS frontier queue, successor to the single-lane processing-unit work queue. Accepts up to `PUSH_LANES` discovered node IDs per cycle from the neighbour-expansion stage. Compacts the valid lanes in lane order into a parametrised-depth circular buffer. Presents a bubble-free first-word-fall-through pop port to the PU dispatcher, with occupancy and almost-full status for upstream throttling.

## Interface
- `NODE_BITS`, 32, node ID width
- `QUEUE_DEPTH`, 1024, entries; power of 2, ≥ 4·`PUSH_LANES`
- `PUSH_LANES`, 4, push lanes; one of 1, 2, 4, 8
- `AFULL_THRESH`, `QUEUE_DEPTH`−2·`PUSH_LANES`, almost_full assertion level
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `clear`  in  1  synchronous flush
- `push_valid`  in  `PUSH_LANES`  per-lane valid mask
- `push_data`  in  `PUSH_LANES`·`NODE_BITS`  lane i at bits [i·NODE_BITS +: NODE_BITS]
- `push_ready`  out  1  free slots ≥ `PUSH_LANES`
- `pop_valid`  out  1  head entry present on `pop_data`
- `pop_data`  out  `NODE_BITS`  head entry, registered
- `pop_ready`  in  1  consumer takes head
- `count`  out  clog2(`QUEUE_DEPTH`)+1  entries accepted and not yet popped
- `almost_full`  out  1  `count` ≥ `AFULL_THRESH`

## Operation
- Push handshake is all-or-nothing.
  - An accept occurs when `push_ready` is high and any `push_valid` bit is set.
  - Every valid lane is written. Lane order is preserved and gaps are squeezed out: the lowest valid lane goes to `wr_ptr`, the next to `wr_ptr`+1, and so on.
  - `wr_ptr` advances by popcount(`push_valid`).
  - When `push_ready` is low, nothing is written. The producer holds its data.
- Pointers are clog2(`QUEUE_DEPTH`) bits wide, with a +1 wrap bit. Wrap modulo `QUEUE_DEPTH` is natural, including a multi-lane write that straddles index `QUEUE_DEPTH`−1 → 0.
- Storage is `PUSH_LANES` banks, each 1W1R, of depth `QUEUE_DEPTH`/`PUSH_LANES`. Slot k lives in bank k mod `PUSH_LANES`, so at most one write per bank per cycle.
- Pop uses a registered output stage:
  - `pop_valid`/`pop_data` hold the head entry.
  - The pop fires on `pop_valid` && `pop_ready`.
  - The bank read address is driven from the next read pointer, so back-to-back pops sustain 1 entry/cycle with no bubbles.
- `count` update: `count` + pushed − popped, both applied in the same cycle. `count` includes the entry held in the output register.
- `push_ready` = (`QUEUE_DEPTH` − `count`) ≥ `PUSH_LANES`. It is combinational from `count`, not from `push_valid`.
- `clear` takes effect at the next edge:
  - pointers, `count`, and `pop_valid` go to 0;
  - it dominates a simultaneous push or pop, and neither takes effect.
  - Memory contents are not cleared.

## Timing
- Reset values: `pop_valid` 0, `pop_data` 0, `count` 0, `push_ready` 1, `almost_full` 0.
- Reset asserted mid-operation discards all contents immediately (asynchronous).
- Push-to-pop latency into an empty queue: push accepted at edge E, `pop_valid` high after edge E+1.
- A pop at edge P with further entries stored: next entry on `pop_data` after P, with `pop_valid` staying high.
- Simultaneous push and pop at `count` = `QUEUE_DEPTH`−`PUSH_LANES`: both proceed.
- A push of a single valid lane when `count` > `QUEUE_DEPTH`−`PUSH_LANES` is not accepted. This is the conservative rule.
- `count` never exceeds `QUEUE_DEPTH`. A pop never occurs with `pop_valid` low.

## Configuration
- `PU_FQ_STATS_EN`
  - Defined: adds outputs `stat_pushed` [31:0], the saturating total of accepted nodes, and `stat_peak` [clog2(`QUEUE_DEPTH`):0], the maximum `count` reached.
  - Both are zeroed by reset and by `clear`.
  - Not defined: the ports and the logic are absent.

## Structure
- The shared package `pu_pkg` holds:
  - the node ID type;
  - the `clog2`-derived pointer/count width function;
  - the lane-count legality check constant.
- Sub-module `pu_fq_lane_compactor` is combinational. It computes a prefix popcount over `push_valid` and produces, per bank, the write enable, the bank index, and the lane-select muxing from the `wr_ptr` offset.

## Test plan
- Reset, then one push of lanes {0,2} = {0xA, 0xB} → `count` 2, `pop_valid` after 2 edges. Pops yield 0xA then 0xB on consecutive cycles.
- Fill a 16-deep, 4-lane queue with four full pushes → `count` 16, `push_ready` low, `almost_full` high. Holding `push_valid` causes no change.
- Set `wr_ptr` to 14 and push 4 lanes {1,2,3,4} → entries at slots 14, 15, 0, 1. Pop order is 1, 2, 3, 4.
- Continuous pushes with lane 1 only, plus an always-ready pop → sequential IDs pop 1/cycle with no bubbles. `count` is steady at 1 or 2.
- Assert `clear` together with a push and a pop at `count` 5 → next cycle `count` 0, `pop_valid` 0, and the pushed data is never popped.
- With `PU_FQ_STATS_EN`: push 7 nodes, pop 3, push 2 → `stat_pushed` 9, `stat_peak` 7.
